// File: rtl/jk_pkg.sv
// jk_pkg: shared types and helpers for the JK response checker.
//   - jk_state_e : checker FSM states (SETTLE, CHECK, HALT)
//   - JK_*       : {j,k} input codes
//   - jk_next    : JK flip-flop next-state function
package jk_pkg;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      CHECK  = 2'd1,
      HALT   = 2'd2
   } jk_state_e;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   function automatic logic jk_next(input logic q, input logic [1:0] jk);
      logic nq;
      case (jk)
         JK_HOLD:   nq = q;
         JK_RESET:  nq = 1'b0;
         JK_SET:    nq = 1'b1;
         default:   nq = ~q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/jk_golden_model.sv
// jk_golden_model: reference JK flip-flop built on jk_pkg::jk_next.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (q -> 0)
//   j, k - JK inputs
//   q    - golden Q
module jk_golden_model
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         q <= jk_next(q, {j, k});
      end
   end

endmodule

// File: rtl/jk_checker.sv
// jk_checker: cycle-accurate response checker for JK flip-flop implementations.
// Tracks a golden JK model from j/k and compares up to LANES observed Q outputs
// each clock, reporting mismatch pulses, sticky flags and saturating counters.
// Optional first-failure capture is built when JK_CHECKER_FIRST_FAIL_EN is defined.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   enable     - qualifies comparisons (golden model always tracks)
//   clr_err    - synchronous clear of flags and counters
//   j, k       - JK stimulus shared with the DUT
//   q_obs      - observed DUT Q, one bit per lane
//   exp_q      - golden Q
//   mismatch   - one-cycle per-lane failure pulse
//   err_sticky - per-lane sticky error flag
//   err_cnt    - per-lane saturating error count, lane i at [i*CNT_W +: CNT_W]
//   chk_cnt    - saturating count of comparison cycles
//   halted     - high while in HALT
//   ff_*       - first-failure record (JK_CHECKER_FIRST_FAIL_EN only)
module jk_checker
   import jk_pkg::*;
#(
   parameter int unsigned LANES         = 3,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter bit          STOP_ON_FAIL  = 1'b0,
   localparam int unsigned LANE_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   clr_err,
   input  logic                   j,
   input  logic                   k,
   input  logic [LANES-1:0]       q_obs,
   output logic                   exp_q,
   output logic [LANES-1:0]       mismatch,
   output logic [LANES-1:0]       err_sticky,
   output logic [LANES*CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0]       chk_cnt,
`ifdef JK_CHECKER_FIRST_FAIL_EN
   output logic                   ff_valid,
   output logic [LANE_W-1:0]      ff_lane,
   output logic [CNT_W-1:0]       ff_cycle,
   output logic [1:0]             ff_jk,
   output logic                   ff_exp,
`endif
   output logic                   halted
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   jk_state_e              state;
   logic [3:0]             settle_cnt;
   logic [3:0]             settle_nxt;
   logic                   settle_done;
   logic [LANES-1:0]       fail;
   logic                   do_cmp;
   logic [CNT_W-1:0]       chk_inc;
   logic [LANES*CNT_W-1:0] err_inc;

   jk_golden_model u_golden (
      .clk (clk),
      .rst (rst),
      .j   (j),
      .k   (k),
      .q   (exp_q)
   );

   always_comb begin
      settle_nxt  = settle_cnt + 4'd1;
      settle_done = (SETTLE_CYCLES == 0) || (32'(settle_nxt) == SETTLE_CYCLES);
      // exp_q is still the pre-edge value here, which is what the DUT Q must match.
      fail        = q_obs ^ {LANES{exp_q}};
      do_cmp      = (state == CHECK) && enable;
      chk_inc     = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + 1'b1;
      err_inc     = err_cnt;
      for (int i = 0; i < LANES; i++) begin
         if (fail[i] && (err_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
            err_inc[i*CNT_W +: CNT_W] = err_cnt[i*CNT_W +: CNT_W] + 1'b1;
         end
      end
   end

`ifdef JK_CHECKER_FIRST_FAIL_EN
   logic [1:0]        jk_prev;
   logic [LANE_W-1:0] low_lane;

   // Lowest failing lane wins on simultaneous failures.
   always_comb begin
      low_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (fail[i]) begin
            low_lane = LANE_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         jk_prev  <= 2'b00;
         ff_valid <= 1'b0;
         ff_lane  <= '0;
         ff_cycle <= '0;
         ff_jk    <= 2'b00;
         ff_exp   <= 1'b0;
      end else begin
         jk_prev <= {j, k};
         if (clr_err) begin
            ff_valid <= 1'b0;
            ff_lane  <= '0;
            ff_cycle <= '0;
            ff_jk    <= 2'b00;
            ff_exp   <= 1'b0;
         end else if (do_cmp && (|fail) && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_lane  <= low_lane;
            ff_cycle <= chk_inc;
            ff_jk    <= jk_prev;
            ff_exp   <= exp_q;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SETTLE;
         settle_cnt <= 4'd0;
         mismatch   <= '0;
         err_sticky <= '0;
         err_cnt    <= '0;
         chk_cnt    <= '0;
         halted     <= 1'b0;
      end else begin
         mismatch <= '0;
         case (state)
            SETTLE: begin
               settle_cnt <= settle_nxt;
               if (settle_done) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (enable) begin
                  chk_cnt    <= chk_inc;
                  mismatch   <= fail;
                  err_sticky <= err_sticky | fail;
                  err_cnt    <= err_inc;
                  if (STOP_ON_FAIL && (|fail)) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
               end
            end
            default: begin
               // HALT: only reset leaves; nothing is compared.
            end
         endcase
         // Clear overrides any same-edge mismatch update.
         if (clr_err) begin
            mismatch   <= '0;
            err_sticky <= '0;
            err_cnt    <= '0;
            chk_cnt    <= '0;
         end
      end
   end

endmodule
